spi_reg_ctrl: RTL

Register-access protocol controller that sits directly above `spi_slave` and sequences it. It decodes the word stream received over SPI into register-bank read/write transactions on a simple req/ack bus, and it feeds response words back into the slave's transmit path. It supports single and auto-increment burst access, and returns a status word during each command frame.

---
 rtl/spi_reg_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// Register-access protocol controller above spi_slave: turns received SPI words
// into req/ack register-bus transactions and feeds status/read words back out.
module spi_reg_ctrl #(
  parameter int K_DWIDTH = 16,
  parameter int K_AWIDTH = 7
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_selected,
  input  logic [K_DWIDTH-1:0] i_rx_data,
  input  logic                i_rx_event,
  output logic [K_DWIDTH-1:0] o_tx_data,
  output logic                o_tx_valid,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [K_AWIDTH-1:0] o_bus_addr,
  output logic [K_DWIDTH-1:0] o_bus_wdata,
  input  logic [K_DWIDTH-1:0] i_bus_rdata,
  input  logic                i_bus_ack,
  output logic                o_overrun,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WR_BUS  = 3'd3,
    S_RD_BUS  = 3'd4,
    S_RD_WAIT = 3'd5
  } state_t;

  localparam logic [K_AWIDTH-1:0] ADDR_ONE = K_AWIDTH'(1);

  state_t              state_q, state_d;
  logic                sel_q, drop_q, inc_q;
  logic                sel_rise, in_bus, in_bus_d, drop;
  logic                load_status, load_rdata, latch_cmd, latch_wdata;
  logic                addr_inc, set_overrun;
  logic [K_DWIDTH-1:0] status_word;

  // Bus handshake: o_bus_req rises together with valid o_bus_we/o_bus_addr/o_bus_wdata,
  // all held stable until the cycle i_bus_ack is high; an ack while req is low is ignored.
  assign sel_rise    = i_selected & ~sel_q;
  assign in_bus      = (state_q == S_WR_BUS) || (state_q == S_RD_BUS);
  assign in_bus_d    = (state_d == S_WR_BUS) || (state_d == S_RD_BUS);
  assign drop        = drop_q | ~i_selected;
  assign o_bus_req   = in_bus;
  assign o_dbg_state = state_q;

  always_comb begin
    status_word                    = '0;
    status_word[K_DWIDTH-1 -: 8]   = 8'hA5;
    status_word[0]                 = o_overrun;
  end

  always_comb begin
    state_d     = state_q;
    load_status = 1'b0;
    load_rdata  = 1'b0;
    latch_cmd   = 1'b0;
    latch_wdata = 1'b0;
    addr_inc    = 1'b0;
    set_overrun = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_rise) begin
          load_status = 1'b1;
          state_d     = S_CMD;
        end
      end
      S_CMD: begin
        if (!i_selected) begin
          state_d = S_IDLE;
        end else if (i_rx_event) begin
          latch_cmd = 1'b1;
          state_d   = i_rx_data[K_DWIDTH-1] ? S_WR_WAIT : S_RD_BUS;
        end
      end
      S_WR_WAIT: begin
        if (!i_selected) begin
          state_d = S_IDLE;
        end else if (i_rx_event) begin
          latch_wdata = 1'b1;
          state_d     = S_WR_BUS;
        end
      end
      S_WR_BUS: begin
        set_overrun = i_rx_event;
        if (i_bus_ack) begin
          addr_inc = inc_q;
          state_d  = drop ? S_IDLE : S_WR_WAIT;
        end
      end
      S_RD_BUS: begin
        set_overrun = i_rx_event;
        // A read completing after deselect is discarded rather than loaded.
        if (i_bus_ack) begin
          if (drop) begin
            state_d = S_IDLE;
          end else begin
            load_rdata = 1'b1;
            state_d    = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (!i_selected) begin
          state_d = S_IDLE;
        end else if (i_rx_event) begin
          addr_inc = inc_q;
          state_d  = S_RD_BUS;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      drop_q      <= 1'b0;
      inc_q       <= 1'b0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_overrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= i_selected;
      // Remembers a deselect seen while a bus request is still outstanding.
      drop_q     <= in_bus_d & drop;
      o_tx_valid <= load_status | load_rdata;
      if (load_status) begin
        o_tx_data <= status_word;
      end else if (load_rdata) begin
        o_tx_data <= i_bus_rdata;
      end
      if (set_overrun) begin
        o_overrun <= 1'b1;
      end else if (load_status) begin
        o_overrun <= 1'b0;
      end
      if (latch_cmd) begin
        o_bus_we   <= i_rx_data[K_DWIDTH-1];
        inc_q      <= i_rx_data[K_DWIDTH-2];
        o_bus_addr <= i_rx_data[K_AWIDTH-1:0];
      end else if (addr_inc) begin
        o_bus_addr <= o_bus_addr + ADDR_ONE;
      end
      if (latch_wdata) begin
        o_bus_wdata <= i_rx_data;
      end
    end
  end

endmodule
